// File: rtl/fetch_pair_queue_pkg.sv
// Shared fetch-stage types and constants: widths, fetch stride and the queue entry layout.
package fetch_pair_queue_pkg;

    localparam int unsigned    INSTR_W          = 32;
    localparam int unsigned    ADDR_W           = 32;
    localparam logic [31:0]    FETCH_STEP       = 32'd8;
    localparam logic [31:0]    RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] i1;
        logic [INSTR_W-1:0] i2;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_pair_queue_pair_fifo.sv
// Circular FIFO of fetched pairs with single-cycle flush; push and pop may coincide when full.
module fetch_pair_queue_pair_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned PtrW  = 2,
    parameter int unsigned Width = 96
) (
    input  logic             clk,
    input  logic             rs_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [Width-1:0] din_i,
    output logic [Width-1:0] dout_o,
    output logic [PtrW:0]    count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    count_q, count_d;

    // Storage needs no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            unique case ({push_i, pop_i})
                2'b10:   count_d = count_q + (PtrW+1)'(1);
                2'b01:   count_d = count_q - (PtrW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rs_n) begin
        if (!rs_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_pair_queue.sv
// Fetch stage: owns the fetch PC, queues instruction pairs from imem and feeds the dual decoder.
module fetch_pair_queue
    import fetch_pair_queue_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned PTR_W    = 2
) (
    input  logic               clk,
    input  logic               rs_n,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_i1,
    input  logic [INSTR_W-1:0] imem_i2,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_i1,
    output logic [INSTR_W-1:0] dec_i2,
    output logic [ADDR_W-1:0]  dec_pc,
    output logic [PTR_W:0]     q_count
);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              push, pop, full;
    fetch_entry_t      wr_entry, head;
    logic [PTR_W:0]    count;

    assign full = (count == (PTR_W+1)'(DEPTH));
    assign pop  = dec_valid & dec_ready;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push = !redirect & (!full | pop);

    assign wr_entry = '{pc: fetch_pc_q, i1: imem_i1, i2: imem_i2};

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc & ~32'h3;
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + FETCH_STEP;
        end
    end

    always_ff @(posedge clk or negedge rs_n) begin
        if (!rs_n) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_pair_queue_pair_fifo #(
        .Depth (DEPTH),
        .PtrW  (PTR_W),
        .Width ($bits(fetch_entry_t))
    ) u_pair_fifo (
        .clk     (clk),
        .rs_n    (rs_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect),
        .din_i   (wr_entry),
        .dout_o  (head),
        .count_o (count)
    );

    assign imem_addr = fetch_pc_q;
    assign q_count   = count;
    assign dec_valid = (count != '0);
    assign dec_pc    = dec_valid ? head.pc : '0;
    assign dec_i1    = dec_valid ? head.i1 : '0;
    assign dec_i2    = dec_valid ? head.i2 : '0;

endmodule

// File: tb/tb_fetch_pair_queue.sv
// Bench for fetch_pair_queue: queue-based reference model checked every cycle plus directed literals.
module tb_fetch_pair_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rs_n;
    logic [31:0] imem_addr, imem_i1, imem_i2;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        dec_valid, dec_ready;
    logic [31:0] dec_i1, dec_i2, dec_pc;
    logic [2:0]  q_count;
    logic [31:0] salt;
    logic        chk_en;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: the queue contents and the next fetch address.
    logic [31:0] m_pc[$];
    logic [31:0] m_i1[$];
    logic [31:0] m_i2[$];
    logic [31:0] m_fpc;

    always #5 clk = ~clk;

    // Instruction memory: each word is its own address XOR a per-phase salt.
    assign imem_i1 = imem_addr ^ salt;
    assign imem_i2 = (imem_addr + 32'd4) ^ salt;

    fetch_pair_queue #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (DEPTH),
        .PTR_W    (2)
    ) dut (
        .clk         (clk),
        .rs_n        (rs_n),
        .imem_addr   (imem_addr),
        .imem_i1     (imem_i1),
        .imem_i2     (imem_i2),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_i1      (dec_i1),
        .dec_i2      (dec_i2),
        .dec_pc      (dec_pc),
        .q_count     (q_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    always @(posedge clk or negedge rs_n) begin
        if (!rs_n) begin
            m_pc.delete(); m_i1.delete(); m_i2.delete();
            m_fpc = 32'h0000_0000;
        end else begin
            bit do_pop, do_push;
            do_pop = (m_pc.size() != 0) && dec_ready;
            if (redirect) begin
                m_pc.delete(); m_i1.delete(); m_i2.delete();
                m_fpc = {redirect_pc[31:2], 2'b00};
            end else begin
                do_push = (m_pc.size() < DEPTH) || do_pop;
                if (do_pop) begin
                    void'(m_pc.pop_front()); void'(m_i1.pop_front()); void'(m_i2.pop_front());
                end
                if (do_push) begin
                    m_pc.push_back(m_fpc);
                    m_i1.push_back(m_fpc ^ salt);
                    m_i2.push_back((m_fpc + 32'd4) ^ salt);
                    m_fpc = m_fpc + 32'd8;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_valid", 32'(dec_valid), 32'(m_pc.size() != 0));
            chk("m_count", 32'(q_count), 32'(m_pc.size()));
            chk("m_addr", imem_addr, m_fpc);
            if (m_pc.size() != 0) begin
                chk("m_pc", dec_pc, m_pc[0]);
                chk("m_i1", dec_i1, m_i1[0]);
                chk("m_i2", dec_i2, m_i2[0]);
            end else begin
                chk("m_pc0", dec_pc, 32'h0);
                chk("m_i10", dec_i1, 32'h0);
                chk("m_i20", dec_i2, 32'h0);
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset(input logic ready);
        rs_n = 1'b0;
        cyc();
        rs_n      = 1'b1;
        dec_ready = ready;
    endtask

    initial begin
        rs_n = 1'b0; dec_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        salt = 32'h0; chk_en = 1'b0;
        cyc(); cyc();
        chk("rst_valid", 32'(dec_valid), 32'h0);
        chk("rst_count", 32'(q_count), 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_pc", dec_pc, 32'h0);
        chk_en = 1'b1;

        // Streaming from reset with word = address.
        rs_n = 1'b1; dec_ready = 1'b1;
        cyc();
        chk("first_valid", 32'(dec_valid), 32'h1);
        chk("first_pc", dec_pc, 32'h0);
        chk("first_i1", dec_i1, 32'h0);
        chk("first_i2", dec_i2, 32'h4);
        cyc(); chk("stream_pc8", dec_pc, 32'h8);
        cyc(); chk("stream_pc16", dec_pc, 32'h10);
        cyc(); chk("stream_pc24", dec_pc, 32'h18);

        // Stall until full, then drain with simultaneous push/pop.
        do_reset(1'b0);
        repeat (6) cyc();
        chk("full_count", 32'(q_count), 32'h4);
        chk("full_addr", imem_addr, 32'h20);
        chk("full_head", dec_pc, 32'h0);
        dec_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk("drain_pc", dec_pc, 32'(8 * k));
            chk("drain_count", 32'(q_count), 32'h4);
            chk("drain_addr", imem_addr, 32'(32 + 8 * k));
        end

        // Redirect with three pairs queued and a concurrent pop.
        do_reset(1'b0);
        repeat (3) cyc();
        chk("pre_redir_count", 32'(q_count), 32'h3);
        salt = 32'h1234_5678;
        redirect = 1'b1; redirect_pc = 32'h0000_1003; dec_ready = 1'b1;
        cyc();
        chk("redir_count", 32'(q_count), 32'h0);
        chk("redir_valid", 32'(dec_valid), 32'h0);
        chk("redir_addr", imem_addr, 32'h1000);
        redirect = 1'b0;
        cyc();
        chk("redir_tgt_valid", 32'(dec_valid), 32'h1);
        chk("redir_tgt_pc", dec_pc, 32'h1000);
        chk("redir_tgt_i1", dec_i1, 32'h1000 ^ 32'h1234_5678);
        chk("redir_tgt_i2", dec_i2, 32'h1004 ^ 32'h1234_5678);

        // Back-to-back redirects: last target wins, nothing queued meanwhile.
        redirect = 1'b1; redirect_pc = 32'h0000_2000;
        cyc();
        redirect_pc = 32'h0000_3006;
        cyc();
        chk("b2b_addr", imem_addr, 32'h3004);
        chk("b2b_count", 32'(q_count), 32'h0);
        redirect = 1'b0;
        cyc();
        chk("b2b_pc", dec_pc, 32'h3004);

        // Address wrap at 2^32 and pointer wrap under an irregular ready pattern.
        salt = 32'hA5A5_0F0F;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF0;
        cyc();
        redirect = 1'b0;
        chk("wrap_start", imem_addr, 32'hFFFF_FFF0);
        cyc();
        chk("wrap_f8", imem_addr, 32'hFFFF_FFF8);
        chk("wrap_head", dec_pc, 32'hFFFF_FFF0);
        cyc();
        chk("wrap_zero", imem_addr, 32'h0000_0000);
        for (int k = 0; k < 24; k++) begin
            dec_ready = (k % 3) != 0;
            cyc();
        end

        // Asynchronous reset between edges with the queue half full.
        redirect = 1'b1; redirect_pc = 32'h0000_0100; dec_ready = 1'b0;
        cyc();
        redirect = 1'b0;
        cyc(); cyc();
        chk("half_count", 32'(q_count), 32'h2);
        #1 rs_n = 1'b0;
        #1;
        chk("async_valid", 32'(dec_valid), 32'h0);
        chk("async_count", 32'(q_count), 32'h0);
        chk("async_addr", imem_addr, 32'h0);
        chk("async_pc", dec_pc, 32'h0);
        chk("async_i1", dec_i1, 32'h0);
        cyc();
        rs_n = 1'b1; dec_ready = 1'b1;
        cyc();
        chk("restart_valid", 32'(dec_valid), 32'h1);
        chk("restart_pc", dec_pc, 32'h0);
        cyc();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
